// File: rtl/block_transfer_seq.sv
// rtl/block_transfer_seq.sv - LDM/STM multi-register transfer sequencer
module block_transfer_seq #(
    parameter int ADDR_W = 32,
    parameter int NREGS  = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              is_load,
    input  logic              pre,
    input  logic              up,
    input  logic              wb,
    input  logic [3:0]        rn,
    input  logic [NREGS-1:0]  reglist,
    input  logic [ADDR_W-1:0] base,
    input  logic [ADDR_W-1:0] reg_rdata,
    input  logic              mem_ready,
    input  logic [ADDR_W-1:0] mem_rdata,
    output logic [3:0]        reg_raddr,
    output logic [3:0]        reg_waddr,
    output logic [ADDR_W-1:0] reg_wdata,
    output logic              reg_we,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [ADDR_W-1:0] mem_wdata,
    output logic              pc_loaded,
    output logic              busy,
    output logic              done
);

    localparam int CW = $clog2(NREGS + 1);

    typedef enum logic [1:0] {IDLE, XFER, WB, DONE} state_t;

    state_t             state;
    logic               is_load_q;
    logic               wb_take_q;
    logic [3:0]         rn_q;
    logic [NREGS-1:0]   list_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [ADDR_W-1:0]  final_q;

    function automatic logic [CW-1:0] popcount(input logic [NREGS-1:0] v);
        logic [CW-1:0] c;
        c = '0;
        for (int i = 0; i < NREGS; i++) begin
            c = c + CW'(v[i]);
        end
        return c;
    endfunction

    function automatic logic [3:0] lowest_idx(input logic [NREGS-1:0] v);
        logic [3:0] idx;
        idx = '0;
        for (int i = NREGS - 1; i >= 0; i--) begin
            if (v[i]) begin
                idx = 4'(i);
            end
        end
        return idx;
    endfunction

    logic [CW-1:0]     cnt;
    logic [ADDR_W-1:0] span;
    logic [ADDR_W-1:0] start_addr;
    logic [3:0]        cur_idx;
    logic              last_beat;
    logic              accept;

    assign cnt       = popcount(reglist);
    assign span      = ADDR_W'(cnt) << 2;
    assign cur_idx   = lowest_idx(list_q);
    assign last_beat = (list_q & (list_q - 1'b1)) == '0;
    assign accept    = (state == XFER) && mem_ready;

    // Whatever the direction, the lowest register sits at the lowest address.
    always_comb begin
        start_addr = base;
        case ({pre, up})
            2'b01:   start_addr = base;
            2'b11:   start_addr = base + ADDR_W'(4);
            2'b00:   start_addr = base - span + ADDR_W'(4);
            default: start_addr = base - span;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= IDLE;
            is_load_q <= 1'b0;
            wb_take_q <= 1'b0;
            rn_q      <= '0;
            list_q    <= '0;
            addr_q    <= '0;
            final_q   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        is_load_q <= is_load;
                        // A loaded base register overrides the writeback.
                        wb_take_q <= wb && !(is_load && reglist[rn]);
                        rn_q      <= rn;
                        list_q    <= reglist;
                        addr_q    <= start_addr;
                        final_q   <= up ? base + span : base - span;
                        state     <= (cnt == '0) ? DONE : XFER;
                    end
                end
                XFER: begin
                    if (mem_ready) begin
                        list_q <= list_q & (list_q - 1'b1);
                        addr_q <= addr_q + ADDR_W'(4);
                        if (last_beat) begin
                            state <= wb_take_q ? WB : DONE;
                        end
                    end
                end
                WB:      state <= DONE;
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        reg_raddr = '0;
        reg_waddr = '0;
        reg_wdata = '0;
        reg_we    = 1'b0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        pc_loaded = 1'b0;
        busy      = (state != IDLE);
        done      = (state == DONE);
        if (state == XFER) begin
            mem_req   = 1'b1;
            mem_we    = !is_load_q;
            mem_addr  = addr_q;
            reg_raddr = cur_idx;
            if (!is_load_q) begin
                mem_wdata = reg_rdata;
            end
            if (accept && is_load_q) begin
                reg_we    = 1'b1;
                reg_waddr = cur_idx;
                reg_wdata = mem_rdata;
                pc_loaded = (cur_idx == 4'd15);
            end
        end else if (state == WB) begin
            reg_we    = 1'b1;
            reg_waddr = rn_q;
            reg_wdata = final_q;
        end
    end

endmodule

// File: tb/tb_block_transfer_seq.sv
// tb/tb_block_transfer_seq.sv - directed self-checking bench for block_transfer_seq
module tb_block_transfer_seq;

    logic        clk = 1'b0;
    logic        reset_n, start, is_load, pre, up, wb, mem_ready;
    logic [3:0]  rn;
    logic [15:0] reglist;
    logic [31:0] base, reg_rdata, mem_rdata;
    logic [3:0]  reg_raddr, reg_waddr;
    logic [31:0] reg_wdata, mem_addr, mem_wdata;
    logic        reg_we, mem_req, mem_we, pc_loaded, busy, done;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    assign reg_rdata = 32'hD000_0000 | 32'(reg_raddr);

    block_transfer_seq #(.ADDR_W(32), .NREGS(16)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .is_load(is_load),
        .pre(pre), .up(up), .wb(wb), .rn(rn), .reglist(reglist), .base(base),
        .reg_rdata(reg_rdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .reg_raddr(reg_raddr), .reg_waddr(reg_waddr), .reg_wdata(reg_wdata),
        .reg_we(reg_we), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .pc_loaded(pc_loaded), .busy(busy), .done(done)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic launch(input logic ld, input logic p, input logic u, input logic w,
                          input logic [3:0] r, input logic [15:0] l, input logic [31:0] b);
        is_load = ld; pre = p; up = u; wb = w; rn = r; reglist = l; base = b;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        step();
        step();
        reset_n = 1'b1;
        #1;
        tests++;
        if ({busy, done, mem_req, reg_we, pc_loaded} !== 5'b0) begin
            fails++;
            $display("FAIL reset_ctrl got %b want 00000", {busy, done, mem_req, reg_we, pc_loaded});
        end
        tests++;
        if ({reg_raddr, reg_waddr, mem_addr, reg_wdata} !== 72'h0) begin
            fails++;
            $display("FAIL reset_data got %h want 0", {reg_raddr, reg_waddr, mem_addr, reg_wdata});
        end
    endtask

    task automatic test_stm_ia();
        logic [31:0] ea [3];
        logic [70:0] obs, exp;
        ea = '{32'h100, 32'h104, 32'h108};
        mem_ready = 1'b1;
        launch(1'b0, 1'b0, 1'b1, 1'b1, 4'd13, 16'h000E, 32'h100);
        for (int i = 0; i < 3; i++) begin
            #1;
            obs = {mem_req, mem_we, mem_addr, reg_raddr, mem_wdata, reg_we};
            exp = {1'b1, 1'b1, ea[i], 4'(i + 1), 32'hD000_0000 | 32'(i + 1), 1'b0};
            tests++;
            if (obs !== exp) begin
                fails++;
                $display("FAIL stm_ia_beat%0d got %h want %h", i, obs, exp);
            end
            step();
        end
        tests++;
        if ({reg_we, reg_waddr, reg_wdata, mem_req, busy, done} !== {1'b1, 4'd13, 32'h10C, 1'b0, 1'b1, 1'b0}) begin
            fails++;
            $display("FAIL stm_ia_wb got %h want %h", {reg_we, reg_waddr, reg_wdata, mem_req, busy, done},
                     {1'b1, 4'd13, 32'h10C, 1'b0, 1'b1, 1'b0});
        end
        step();
        tests++;
        if ({done, busy, reg_we, mem_req} !== 4'b1100) begin
            fails++;
            $display("FAIL stm_ia_done got %b want 1100", {done, busy, reg_we, mem_req});
        end
        step();
        tests++;
        if ({done, busy} !== 2'b00) begin
            fails++;
            $display("FAIL stm_ia_idle got %b want 00", {done, busy});
        end
    endtask

    task automatic test_ldm_db();
        logic [31:0] ea [3];
        logic [31:0] dat [3];
        logic [3:0]  idx [3];
        logic [71:0] obs, exp;
        ea  = '{32'h1F4, 32'h1F8, 32'h1FC};
        dat = '{32'hA0, 32'hA1, 32'hA2};
        idx = '{4'd0, 4'd1, 4'd15};
        mem_ready = 1'b1;
        launch(1'b1, 1'b1, 1'b0, 1'b0, 4'd5, 16'h8003, 32'h200);
        for (int i = 0; i < 3; i++) begin
            mem_rdata = dat[i];
            #1;
            obs = {mem_req, mem_we, mem_addr, reg_we, reg_waddr, reg_wdata, pc_loaded, 1'b0};
            exp = {1'b1, 1'b0, ea[i], 1'b1, idx[i], dat[i], (i == 2), 1'b0};
            tests++;
            if (obs !== exp) begin
                fails++;
                $display("FAIL ldm_db_beat%0d got %h want %h", i, obs, exp);
            end
            step();
        end
        tests++;
        if ({done, reg_we, mem_req, pc_loaded} !== 4'b1000) begin
            fails++;
            $display("FAIL ldm_db_done got %b want 1000", {done, reg_we, mem_req, pc_loaded});
        end
        step();
    endtask

    task automatic test_stall();
        mem_ready = 1'b0;
        mem_rdata = 32'h77;
        launch(1'b1, 1'b1, 1'b1, 1'b0, 4'd0, 16'h0010, 32'h40);
        for (int i = 0; i < 3; i++) begin
            #1;
            tests++;
            if ({mem_req, mem_addr, reg_we, reg_raddr} !== {1'b1, 32'h44, 1'b0, 4'd4}) begin
                fails++;
                $display("FAIL stall_hold%0d got %h want %h", i, {mem_req, mem_addr, reg_we, reg_raddr},
                         {1'b1, 32'h44, 1'b0, 4'd4});
            end
            step();
        end
        mem_ready = 1'b1;
        #1;
        tests++;
        if ({reg_we, reg_waddr, reg_wdata} !== {1'b1, 4'd4, 32'h77}) begin
            fails++;
            $display("FAIL stall_write got %h want %h", {reg_we, reg_waddr, reg_wdata}, {1'b1, 4'd4, 32'h77});
        end
        step();
        tests++;
        if ({done, reg_we, mem_req} !== 3'b100) begin
            fails++;
            $display("FAIL stall_done got %b want 100", {done, reg_we, mem_req});
        end
        step();
    endtask

    task automatic test_base_in_list();
        mem_ready = 1'b1;
        mem_rdata = 32'h55;
        launch(1'b1, 1'b0, 1'b1, 1'b1, 4'd2, 16'h0004, 32'h80);
        #1;
        tests++;
        if ({reg_we, reg_waddr, reg_wdata, mem_addr} !== {1'b1, 4'd2, 32'h55, 32'h80}) begin
            fails++;
            $display("FAIL bil_load got %h want %h", {reg_we, reg_waddr, reg_wdata, mem_addr},
                     {1'b1, 4'd2, 32'h55, 32'h80});
        end
        step();
        tests++;
        if ({done, reg_we} !== 2'b10) begin
            fails++;
            $display("FAIL bil_no_wb got %b want 10", {done, reg_we});
        end
        step();
    endtask

    task automatic test_empty_and_ignore();
        mem_ready = 1'b1;
        launch(1'b0, 1'b0, 1'b1, 1'b1, 4'd1, 16'h0000, 32'h300);
        #1;
        tests++;
        if ({done, busy, mem_req, reg_we} !== 4'b1100) begin
            fails++;
            $display("FAIL empty_done got %b want 1100", {done, busy, mem_req, reg_we});
        end
        step();
        launch(1'b0, 1'b0, 1'b1, 1'b0, 4'd1, 16'h0003, 32'h300);
        is_load = 1'b1; reglist = 16'hF000; base = 32'h900; start = 1'b1;
        #1;
        tests++;
        if ({mem_req, mem_we, mem_addr, reg_raddr} !== {1'b1, 1'b1, 32'h300, 4'd0}) begin
            fails++;
            $display("FAIL ignore_beat0 got %h want %h", {mem_req, mem_we, mem_addr, reg_raddr},
                     {1'b1, 1'b1, 32'h300, 4'd0});
        end
        step();
        start = 1'b0;
        #1;
        tests++;
        if ({mem_req, mem_we, mem_addr, reg_raddr, reg_we} !== {1'b1, 1'b1, 32'h304, 4'd1, 1'b0}) begin
            fails++;
            $display("FAIL ignore_beat1 got %h want %h", {mem_req, mem_we, mem_addr, reg_raddr, reg_we},
                     {1'b1, 1'b1, 32'h304, 4'd1, 1'b0});
        end
        step();
        tests++;
        if ({done, mem_req} !== 2'b10) begin
            fails++;
            $display("FAIL ignore_done got %b want 10", {done, mem_req});
        end
        step();
    endtask

    task automatic test_wrap();
        mem_ready = 1'b1;
        launch(1'b0, 1'b1, 1'b0, 1'b1, 4'd1, 16'h0101, 32'h4);
        #1;
        tests++;
        if ({mem_addr, reg_raddr} !== {32'hFFFF_FFFC, 4'd0}) begin
            fails++;
            $display("FAIL wrap_beat0 got %h want %h", {mem_addr, reg_raddr}, {32'hFFFF_FFFC, 4'd0});
        end
        step();
        tests++;
        if ({mem_addr, reg_raddr, mem_wdata} !== {32'h0, 4'd8, 32'hD000_0008}) begin
            fails++;
            $display("FAIL wrap_beat1 got %h want %h", {mem_addr, reg_raddr, mem_wdata},
                     {32'h0, 4'd8, 32'hD000_0008});
        end
        step();
        tests++;
        if ({reg_we, reg_waddr, reg_wdata} !== {1'b1, 4'd1, 32'hFFFF_FFFC}) begin
            fails++;
            $display("FAIL wrap_wb got %h want %h", {reg_we, reg_waddr, reg_wdata}, {1'b1, 4'd1, 32'hFFFF_FFFC});
        end
        step();
        step();
    endtask

    task automatic test_reset_mid();
        mem_ready = 1'b1;
        launch(1'b0, 1'b0, 1'b1, 1'b1, 4'd6, 16'h00F0, 32'h500);
        step();
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        #1;
        tests++;
        if ({busy, mem_req, reg_we, done} !== 4'b0000) begin
            fails++;
            $display("FAIL midreset_idle got %b want 0000", {busy, mem_req, reg_we, done});
        end
        launch(1'b0, 1'b0, 1'b0, 1'b1, 4'd3, 16'h0001, 32'h10);
        #1;
        tests++;
        if ({mem_req, mem_addr, reg_raddr} !== {1'b1, 32'h10, 4'd0}) begin
            fails++;
            $display("FAIL midreset_beat got %h want %h", {mem_req, mem_addr, reg_raddr}, {1'b1, 32'h10, 4'd0});
        end
        step();
        tests++;
        if ({reg_we, reg_waddr, reg_wdata, mem_req} !== {1'b1, 4'd3, 32'hC, 1'b0}) begin
            fails++;
            $display("FAIL midreset_wb got %h want %h", {reg_we, reg_waddr, reg_wdata, mem_req},
                     {1'b1, 4'd3, 32'hC, 1'b0});
        end
        step();
        tests++;
        if (done !== 1'b1) begin
            fails++;
            $display("FAIL midreset_done got %b want 1", done);
        end
        step();
    endtask

    initial begin
        reset_n = 1'b1; start = 1'b0; is_load = 1'b0; pre = 1'b0; up = 1'b0; wb = 1'b0;
        rn = '0; reglist = '0; base = '0; mem_ready = 1'b0; mem_rdata = '0;
        #2;
        test_reset();
        test_stm_ia();
        test_ldm_db();
        test_stall();
        test_base_in_list();
        test_empty_and_ignore();
        test_wrap();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
